// File: rtl/video_sig_gen.sv
// Raster timing generator: free-running hcount/vcount with registered sync, active-draw,
// new-frame and frame-count flags. Define VSG_ALIGN_EN to delay the flags by ALIGN_STAGES cycles.
module video_sig_gen #(
    parameter int ACTIVE_H     = 1280,
    parameter int H_FP         = 110,
    parameter int H_SYNC       = 40,
    parameter int H_BP         = 220,
    parameter int ACTIVE_V     = 720,
    parameter int V_FP         = 5,
    parameter int V_SYNC       = 5,
    parameter int V_BP         = 20,
    parameter int FPS          = 60,
    parameter int ALIGN_STAGES = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int TOTAL_PIXELS = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_LINES  = ACTIVE_V + V_FP + V_SYNC + V_BP;
    localparam int HS_START     = ACTIVE_H + H_FP;
    localparam int HS_END       = HS_START + H_SYNC;
    localparam int VS_START     = ACTIVE_V + V_FP;
    localparam int VS_END       = VS_START + V_SYNC;

    localparam logic [10:0] H_LAST  = 11'(TOTAL_PIXELS - 1);
    localparam logic [9:0]  V_LAST  = 10'(TOTAL_LINES - 1);
    localparam logic [5:0]  FC_LAST = 6'(FPS - 1);

    generate
        if (TOTAL_PIXELS > 2048 || TOTAL_LINES > 1024 || FPS > 64 || FPS < 1 || ALIGN_STAGES < 1) begin : g_cfg_error
            $error("video_sig_gen: timing parameters out of range");
        end
    endgenerate

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        ad_q, ad_d;
    logic        nf_q, nf_d;
    logic [5:0]  fc_q, fc_d;
    logic [11:0] h_ext;
    logic [10:0] v_ext;

    // Flags are decoded from the next-state counts so they land in the same cycle as the counts.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
        h_ext = {1'b0, hcount_d};
        v_ext = {1'b0, vcount_d};
        hs_d  = (h_ext >= 12'(HS_START)) && (h_ext < 12'(HS_END));
        vs_d  = (v_ext >= 11'(VS_START)) && (v_ext < 11'(VS_END));
        ad_d  = (h_ext < 12'(ACTIVE_H)) && (v_ext < 11'(ACTIVE_V));
        nf_d  = (h_ext == 12'(ACTIVE_H)) && (v_ext == 11'(ACTIVE_V));
        fc_d  = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 6'd1;
        end
    end

    // Reset parks the counters on the last pixel so the first free-running edge shows (0,0).
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;

`ifdef VSG_ALIGN_EN
    logic [9:0] flags_q;
    logic [9:0] align_q [ALIGN_STAGES];
    logic [9:0] align_d [ALIGN_STAGES];
    genvar gi;

    assign flags_q = {hs_q, vs_q, ad_q, nf_q, fc_q};

    always_comb begin
        align_d[0] = flags_q;
        for (int i = 1; i < ALIGN_STAGES; i++) begin
            align_d[i] = align_q[i-1];
        end
    end

    generate
        for (gi = 0; gi < ALIGN_STAGES; gi++) begin : g_align
            always_ff @(posedge pixel_clk_in) begin
                if (rst_in) begin
                    align_q[gi] <= '0;
                end else begin
                    align_q[gi] <= align_d[gi];
                end
            end
        end
    endgenerate

    assign {hs_out, vs_out, ad_out, nf_out, fc_out} = align_q[ALIGN_STAGES-1];
`else
    assign hs_out = hs_q;
    assign vs_out = vs_q;
    assign ad_out = ad_q;
    assign nf_out = nf_q;
    assign fc_out = fc_q;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Scoreboard bench for video_sig_gen on a reduced raster; expected outputs come from
// arithmetic on the cycle count since reset release, checked by an independent monitor.
module tb_video_sig_gen;

    localparam int AH = 16, HFP = 3, HSW = 4, HBP = 5;
    localparam int AV = 10, VFP = 2, VSW = 2, VBP = 3;
    localparam int NFPS = 5;
    localparam int AS = 4;
    localparam int TP = AH + HFP + HSW + HBP;
    localparam int TL = AV + VFP + VSW + VBP;
    localparam int FRAME = TP * TL;
    localparam int NF_OFF = AV * TP + AH;
    localparam int N_CYC = 6000;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [5:0]  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hs_out, vs_out, ad_out, nf_out;
    logic [5:0]  fc_out;

    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    video_sig_gen #(
        .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .FPS(NFPS), .ALIGN_STAGES(AS)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in(rst_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hs_out(hs_out),
        .vs_out(vs_out),
        .ad_out(ad_out),
        .nf_out(nf_out),
        .fc_out(fc_out)
    );

    // Raster position and frame count t cycles after reset release.
    function automatic exp_t model(int t);
        exp_t e;
        int h, v, n;
        h = t % TP;
        v = (t / TP) % TL;
        n = (t >= NF_OFF) ? (t - NF_OFF) / FRAME + 1 : 0;
        e.h  = 11'(h);
        e.v  = 10'(v);
        e.hs = (h >= AH + HFP) && (h < AH + HFP + HSW);
        e.vs = (v >= AV + VFP) && (v < AV + VFP + VSW);
        e.ad = (h < AH) && (v < AV);
        e.nf = (h == AH) && (v == AV);
        e.fc = 6'(n % NFPS);
        return e;
    endfunction

    task automatic check(input string name, input int cyc, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    // Stimulus: choose rst_in for the coming edge and push the expected post-edge outputs.
    initial begin
        int   t;
        int   rst_left;
        exp_t e;
        logic [9:0] dq[$];
        rst_in   = 1'b1;
        t        = 0;
        rst_left = 0;
        for (int i = 0; i < AS; i++) dq.push_back('0);
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            if (c < 3) begin
                rst_in = 1'b1;
            end else if (rst_left > 0) begin
                rst_in = 1'b1;
                rst_left--;
            end else if (c == 2700) begin
                rst_in = 1'b1;
            end else if (c > 2700 && $urandom_range(0, 499) == 0) begin
                rst_in = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst_in = 1'b0;
            end

            if (rst_in) begin
                e = '0;
                e.h = 11'(TP - 1);
                e.v = 10'(TL - 1);
                t = 0;
                dq.delete();
                for (int i = 0; i < AS; i++) dq.push_back('0);
            end else begin
                e = model(t);
                t++;
`ifdef VSG_ALIGN_EN
                dq.push_back({e.hs, e.vs, e.ad, e.nf, e.fc});
                {e.hs, e.vs, e.ad, e.nf, e.fc} = dq.pop_front();
`endif
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        @(negedge clk);
        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", n, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("hcount", n, int'(hcount_out), int'(e.h));
                check("vcount", n, int'(vcount_out), int'(e.v));
                check("hs",     n, int'(hs_out),     int'(e.hs));
                check("vs",     n, int'(vs_out),     int'(e.vs));
                check("ad",     n, int'(ad_out),     int'(e.ad));
                check("nf",     n, int'(nf_out),     int'(e.nf));
                check("fc",     n, int'(fc_out),     int'(e.fc));
                if (e.nf) begin
                    $display("frame cyc=%0d h=%0d v=%0d fc=%0d", n, hcount_out, vcount_out, fc_out);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
